// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_2.sv
// 2:4 one-hot decoder with enable; output is all-zero when disabled.
module decoder_2
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] in_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] out_o
);

  always_comb begin
    out_o = '0;
    if (en_i) begin
      out_o[in_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit and a one-cycle
// turnaround gap between grants. Every output comes from registered state.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] grant_out,
  output logic [IDX_W-1:0] grant_idx_out,
  output logic             grant_valid_out,
  output logic             timeout_out
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W:0]     win;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ... mod 4.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] req,
                                          input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        pick = {1'b1, cand};
      end
    end
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    win       = pick(req_in, ptr_q);
    unique case (state_q)
      IDLE, RECOVER: begin
        if (en_in && win[IDX_W]) begin
          state_d = GRANT;
          idx_d   = win[IDX_W-1:0];
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!en_in || !req_in[idx_q]) begin
          state_d = RECOVER;
          ptr_d   = idx_q + IDX_W'(1);
        end else if (hold_q == HoldLast) begin
          state_d   = RECOVER;
          timeout_d = 1'b1;
          ptr_d     = idx_q + IDX_W'(1);
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_valid_out = (state_q == GRANT);
    grant_idx_out   = idx_q;
    timeout_out     = timeout_q;
  end

  decoder_2 u_decoder (
    .in_i  (idx_q),
    .en_i  (grant_valid_out),
    .out_o (grant_out)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_rr_arbiter_4;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       gvalid;
  logic       tout;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .en_in           (en),
    .req_in          (req),
    .grant_out       (grant),
    .grant_idx_out   (gidx),
    .grant_valid_out (gvalid),
    .timeout_out     (tout)
  );

  always #5 clk = ~clk;

  // Monitor: every negedge with a pending expectation compares all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{g: grant, i: gidx, v: gvalid, t: tout};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                 nm, a.g, a.i, a.v, a.t, e.g, e.i, e.v, e.t);
      end
    end
  end

  // Apply inputs for one edge, then queue the outputs expected after that edge.
  task automatic step(input logic e_en, input logic [3:0] e_req, input logic [3:0] eg,
                      input logic [1:0] ei, input logic ev, input logic et, input string nm);
    en  = e_en;
    req = e_req;
    @(posedge clk);
    exp_q.push_back('{g: eg, i: ei, v: ev, t: et});
    name_q.push_back(nm);
    #1;
  endtask

  task automatic direct_check(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, act, want);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset_hold0");
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset_hold1");
    rst = 1'b0;

    // Reset asserted mid-grant clears outputs without a clock edge.
    step(1, 4'b0010, 4'b0010, 2'd1, 1, 0, "rst_pre_grant0");
    step(1, 4'b0010, 4'b0010, 2'd1, 1, 0, "rst_pre_grant1");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    direct_check("rst_async_clear", {grant, gidx, gvalid, tout}, 8'b0000_00_0_0);
    step(1, 4'b0010, 4'b0000, 2'd0, 0, 0, "rst_held");
    rst = 1'b0;
    step(1, 4'b0010, 4'b0010, 2'd1, 1, 0, "rst_release_grant");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, 0, "rst_recover");
    step(1, 4'b0000, 4'b0000, 2'd1, 0, 0, "rst_idle");

    // Single request, 3 grant cycles; ptr ends at 3 (shown by 1001 picking 3).
    step(1, 4'b0100, 4'b0100, 2'd2, 1, 0, "single_g0");
    step(1, 4'b0100, 4'b0100, 2'd2, 1, 0, "single_g1");
    step(1, 4'b0100, 4'b0100, 2'd2, 1, 0, "single_g2");
    step(1, 4'b0000, 4'b0000, 2'd2, 0, 0, "single_recover");
    step(1, 4'b0000, 4'b0000, 2'd2, 0, 0, "single_idle");
    step(1, 4'b1001, 4'b1000, 2'd3, 1, 0, "single_ptr3");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, 0, "ptr3_recover");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, 0, "ptr3_idle");

    // Round-robin: each winner drops after two granted cycles, re-raises in RECOVER.
    for (int r = 0; r < 5; r++) begin
      logic [3:0] oh;
      logic [1:0] ix;
      ix = 2'(r % 4);
      oh = 4'b0001 << ix;
      step(1, 4'b1111, oh, ix, 1, 0, $sformatf("rr%0d_g0", r));
      step(1, 4'b1111, oh, ix, 1, 0, $sformatf("rr%0d_g1", r));
      step(1, 4'b1111 & ~oh, 4'b0000, ix, 0, 0, $sformatf("rr%0d_gap", r));
    end
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "rr_idle");

    // Priority rotation: after serving 1, a re-raised 0011 picks 0.
    step(1, 4'b0010, 4'b0010, 2'd1, 1, 0, "rot_g1a");
    step(1, 4'b0011, 4'b0010, 2'd1, 1, 0, "rot_g1b");
    step(1, 4'b0001, 4'b0000, 2'd1, 0, 0, "rot_recover");
    step(1, 4'b0011, 4'b0001, 2'd0, 1, 0, "rot_winner0");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "rot_recover2");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "rot_idle");

    // Hold limit: 8 granted cycles, timeout in the RECOVER cycle, then re-grant.
    for (int c = 0; c < 8; c++) begin
      step(1, 4'b0001, 4'b0001, 2'd0, 1, 0, $sformatf("hold_g%0d", c));
    end
    step(1, 4'b0001, 4'b0000, 2'd0, 0, 1, "hold_timeout");
    step(1, 4'b0001, 4'b0001, 2'd0, 1, 0, "hold_regrant");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "hold_recover");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "hold_idle");

    // Enable: drop mid-grant revokes with no timeout; no grant while disabled.
    step(1, 4'b0100, 4'b0100, 2'd2, 1, 0, "en_grant2");
    step(0, 4'b0100, 4'b0000, 2'd2, 0, 0, "en_revoke");
    step(0, 4'b1000, 4'b0000, 2'd2, 0, 0, "en_off_a");
    step(0, 4'b1000, 4'b0000, 2'd2, 0, 0, "en_off_b");
    step(1, 4'b1000, 4'b1000, 2'd3, 1, 0, "en_on_grant3");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, 0, "en_recover");
    step(1, 4'b0000, 4'b0000, 2'd3, 0, 0, "en_idle");

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
